// File: rtl/multicycle_control_unit_if.sv
// Signal bundle between the multicycle control unit, the cache handshakes and
// the datapath. The control unit uses the master view; the environment (memory
// interface, datapath, testbench) uses the slave view.
interface multicycle_control_unit_if;
    logic [31:0] instr;
    logic        ihit;
    logic        dhit;
    logic        zero;
    logic        link_inv;

    logic        iREN;
    logic        dREN;
    logic        dWEN;
    logic        pc_wen;
    logic [1:0]  pc_src;
    logic        regwr;
    logic [1:0]  regdst;
    logic [1:0]  memtoreg;
    logic [1:0]  alu_src;
    logic [3:0]  alu_op;
    logic        extop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [31:0] sc_result;
    logic        halt;
    logic [2:0]  state_o;

    modport master (
        input  instr, ihit, dhit, zero, link_inv,
        output iREN, dREN, dWEN, pc_wen, pc_src, regwr, regdst, memtoreg,
               alu_src, alu_op, extop, rs, rt, rd, shamt, imm16, sc_result,
               halt, state_o
    );

    modport slave (
        output instr, ihit, dhit, zero, link_inv,
        input  iREN, dREN, dWEN, pc_wen, pc_src, regwr, regdst, memtoreg,
               alu_src, alu_op, extop, rs, rt, rd, shamt, imm16, sc_result,
               halt, state_o
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS sequencing controller. Latches the instruction on an icache
// hit, walks it through DECODE/EXEC/MEM/WB, and drives per-state datapath
// enables. Carries an LL/SC link flag that snoops can invalidate.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   FETCH  | iREN high, wait for ihit, capture instruction word
//   DECODE | one idle cycle; route halt / illegal / normal
//   EXEC   | branches and jumps retire here; SC link check
//   MEM    | hold dREN/dWEN until dhit; SW retires here
//   WB     | single regwr pulse plus PC update
//   HALT   | everything off; only reset leaves
module multicycle_control_unit #(
    parameter bit LLSC_EN         = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        link_q, link_d;
    logic        sc_ok_q, sc_ok_d;

    logic [5:0]  op;
    logic [5:0]  funct;

    logic        is_j, is_jal, is_jr, is_beq, is_bne;
    logic        is_lw, is_sw, is_ll, is_sc, is_halt, is_illegal;
    aluop_t      alu_op_dec;
    logic [1:0]  alu_src_dec;
    logic [1:0]  regdst_dec;
    logic [1:0]  memtoreg_dec;
    logic        extop_dec;

    logic        iren, dren, dwen, pc_wen, regwr;
    logic [1:0]  pc_src;

    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];

    // Static decode of the latched instruction (matches the single-cycle tables).
    always_comb begin
        is_j         = 1'b0;
        is_jal       = 1'b0;
        is_jr        = 1'b0;
        is_beq       = 1'b0;
        is_bne       = 1'b0;
        is_lw        = 1'b0;
        is_sw        = 1'b0;
        is_ll        = 1'b0;
        is_sc        = 1'b0;
        is_halt      = 1'b0;
        is_illegal   = 1'b0;
        alu_op_dec   = ALU_ADD;
        alu_src_dec  = 2'd0;
        regdst_dec   = 2'd0;
        extop_dec    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:           alu_op_dec = ALU_SLL;
                    FN_SRL:           alu_op_dec = ALU_SRL;
                    FN_JR:            is_jr      = 1'b1;
                    FN_ADD, FN_ADDU:  alu_op_dec = ALU_ADD;
                    FN_SUB, FN_SUBU:  alu_op_dec = ALU_SUB;
                    FN_AND:           alu_op_dec = ALU_AND;
                    FN_OR:            alu_op_dec = ALU_OR;
                    FN_XOR:           alu_op_dec = ALU_XOR;
                    FN_NOR:           alu_op_dec = ALU_NOR;
                    FN_SLT:           alu_op_dec = ALU_SLT;
                    FN_SLTU:          alu_op_dec = ALU_SLTU;
                    default:          is_illegal = 1'b1;
                endcase
            end
            OP_J:   is_j = 1'b1;
            OP_JAL: begin
                is_jal     = 1'b1;
                regdst_dec = 2'd2;
            end
            OP_BEQ, OP_BNE: begin
                is_beq     = (op == OP_BEQ);
                is_bne     = (op == OP_BNE);
                alu_op_dec = ALU_SUB;
                extop_dec  = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                regdst_dec  = 2'd1;
                alu_src_dec = 2'd1;
                extop_dec   = 1'b1;
                alu_op_dec  = ALU_ADD;
            end
            OP_SLTI, OP_SLTIU: begin
                regdst_dec  = 2'd1;
                alu_src_dec = 2'd1;
                extop_dec   = 1'b1;
                alu_op_dec  = (op == OP_SLTI) ? ALU_SLT : ALU_SLTU;
            end
            OP_ANDI: begin
                regdst_dec  = 2'd1;
                alu_src_dec = 2'd1;
                alu_op_dec  = ALU_AND;
            end
            OP_ORI: begin
                regdst_dec  = 2'd1;
                alu_src_dec = 2'd1;
                alu_op_dec  = ALU_OR;
            end
            OP_XORI: begin
                regdst_dec  = 2'd1;
                alu_src_dec = 2'd1;
                alu_op_dec  = ALU_XOR;
            end
            OP_LUI: begin
                // rs is $0 for LUI, so OR passes the shifted immediate through
                regdst_dec  = 2'd1;
                alu_src_dec = 2'd2;
                alu_op_dec  = ALU_OR;
            end
            OP_LW, OP_SW: begin
                is_lw       = (op == OP_LW);
                is_sw       = (op == OP_SW);
                regdst_dec  = 2'd1;
                alu_src_dec = 2'd1;
                extop_dec   = 1'b1;
                alu_op_dec  = ALU_ADD;
            end
            OP_LL, OP_SC: begin
                if (LLSC_EN) begin
                    is_ll       = (op == OP_LL);
                    is_sc       = (op == OP_SC);
                    regdst_dec  = 2'd1;
                    alu_src_dec = 2'd1;
                    extop_dec   = 1'b1;
                    alu_op_dec  = ALU_ADD;
                end else begin
                    is_illegal = 1'b1;
                end
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase

        if (is_lw || is_ll) begin
            memtoreg_dec = 2'd1;
        end else if (is_jal) begin
            memtoreg_dec = 2'd2;
        end else if (is_sc) begin
            memtoreg_dec = 2'd3;
        end else begin
            memtoreg_dec = 2'd0;
        end
    end

    // Next-state, enables, IR capture, link flag and SC result.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        link_d  = link_q;
        sc_ok_d = sc_ok_q;
        iren    = 1'b0;
        dren    = 1'b0;
        dwen    = 1'b0;
        pc_wen  = 1'b0;
        pc_src  = 2'd0;
        regwr   = 1'b0;

        // Snoop invalidate; an LL completing this cycle overrides it below.
        if (bus.link_inv) begin
            link_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                iren = 1'b1;
                if (bus.ihit) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_illegal) begin
                    if (HALT_ON_ILLEGAL) begin
                        state_d = S_HALT;
                    end else begin
                        pc_wen  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq || is_bne) begin
                    pc_wen  = 1'b1;
                    pc_src  = (bus.zero ^ is_bne) ? 2'd1 : 2'd0;
                    state_d = S_FETCH;
                end else if (is_j) begin
                    pc_wen  = 1'b1;
                    pc_src  = 2'd2;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_wen  = 1'b1;
                    pc_src  = 2'd3;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw || is_ll) begin
                    state_d = S_MEM;
                end else if (is_sc) begin
                    if (link_q && !bus.link_inv) begin
                        state_d = S_MEM;
                    end else begin
                        sc_ok_d = 1'b0;
                        link_d  = 1'b0;
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dren = is_lw || is_ll;
                dwen = is_sw || is_sc;
                if (bus.dhit) begin
                    if (is_ll) begin
                        link_d = 1'b1;
                    end
                    if (is_sc) begin
                        sc_ok_d = 1'b1;
                        link_d  = 1'b0;
                    end
                    if (is_sw) begin
                        pc_wen  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regwr   = 1'b1;
                pc_wen  = 1'b1;
                pc_src  = is_jal ? 2'd2 : 2'd0;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Controller state registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            link_q  <= 1'b0;
            sc_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            link_q  <= link_d;
            sc_ok_q <= sc_ok_d;
        end
    end

    assign bus.iREN      = iren;
    assign bus.dREN      = dren;
    assign bus.dWEN      = dwen;
    assign bus.pc_wen    = pc_wen;
    assign bus.pc_src    = pc_src;
    assign bus.regwr     = regwr;
    assign bus.regdst    = regdst_dec;
    assign bus.memtoreg  = memtoreg_dec;
    assign bus.alu_src   = alu_src_dec;
    assign bus.alu_op    = alu_op_dec;
    assign bus.extop     = extop_dec;
    assign bus.rs        = ir_q[25:21];
    assign bus.rt        = ir_q[20:16];
    assign bus.rd        = ir_q[15:11];
    assign bus.shamt     = ir_q[10:6];
    assign bus.imm16     = ir_q[15:0];
    assign bus.sc_result = {31'd0, sc_ok_q};
    assign bus.halt      = (state_q == S_HALT);
    assign bus.state_o   = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequencing controller for the multicycle MIPS datapath. It replaces the purely combinational decoder with a FETCH/DECODE/EXEC/MEM/WB/HALT state machine.
- Latches the instruction, handshakes with the instruction and data caches (ihit/dhit), and drives per-state datapath enables.
- Adds LL/SC support through an internal link-valid flag that can be invalidated by snoops.
- Sits between the memory interface (icache/dcache) and the datapath muxes and register file.

Parameters:
LLSC_EN, 1, 1 = LL/SC decoded and link flag implemented; 0 = LL/SC treated as illegal opcodes.
HALT_ON_ILLEGAL, 1, 1 = unknown opcode or funct enters HALT; 0 = executes as NOP (PC+4 only).

Ports:
CLK  in  1  system clock, rising edge.
nRST  in  1  asynchronous active-low reset.
instr  in  32  instruction word from icache; sampled only in FETCH when ihit=1.
ihit  in  1  instruction read complete.
dhit  in  1  data read/write complete.
zero  in  1  ALU zero flag; valid in EXEC.
link_inv  in  1  one-cycle snoop invalidate of the linked address.
iREN  out  1  instruction read request.
dREN  out  1  data read request.
dWEN  out  1  data write request.
pc_wen  out  1  PC register write enable.
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs (JR).
regwr  out  1  register file write enable.
regdst  out  2  0=rd, 1=rt, 2=$31.
memtoreg  out  2  0=ALU, 1=dload, 2=PC+4, 3=sc_result.
alu_src  out  2  0=rt, 1=extended imm16, 2=LUI shifted imm.
alu_op  out  4  aluop_t encoding.
extop  out  1  1=sign-extend, 0=zero-extend.
rs, rt, rd  out  5 each  fields of latched IR.
shamt  out  5  latched IR[10:6].
imm16  out  16  latched IR[15:0].
sc_result  out  32  1 if SC succeeded, else 0.
halt  out  1  sticky halt.
state_o  out  3  current state for debug (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5).

Behaviour:
- Reset (nRST low, takes effect asynchronously, including mid-instruction):
  - State=FETCH, IR=0, link flag=0, halt=0.
  - Outputs during reset: iREN=1, all other enables 0, pc_src=0, regwr=0.
- All outputs are combinational from state, latched IR, zero and link flag. IR changes only on the FETCH-with-ihit edge.
- pc_wen pulses exactly once per retired instruction, in the last cycle before returning to FETCH.
- FETCH: iREN=1. On ihit, capture instr into IR and go to DECODE; otherwise hold (no timeout).
- DECODE: one cycle, no enables asserted.
  - HALT opcode goes to HALT.
  - Illegal opcode goes to HALT (HALT_ON_ILLEGAL=1), or to FETCH with pc_wen=1, pc_src=0 (HALT_ON_ILLEGAL=0).
  - Everything else goes to EXEC.
- EXEC:
  - BEQ/BNE: pc_wen=1, pc_src=1 if (zero XOR BNE), else 0; go to FETCH.
  - J: pc_src=2, go to FETCH.
  - JR: pc_src=3, go to FETCH.
  - LW/SW/LL: go to MEM.
  - SC with link flag=1 and no link_inv this cycle: go to MEM.
  - SC otherwise: go to WB with sc_result=0 and no memory access.
  - Others (R-type, immediates, LUI, JAL): go to WB.
- MEM: dREN=1 for LW/LL, dWEN=1 for SW/SC. Requests are held stable until dhit. On dhit:
  - SW goes to FETCH with pc_wen=1.
  - Loads and SC go to WB.
- WB: regwr=1 for exactly one cycle, pc_wen=1, then go to FETCH.
  - JAL: pc_src=2, regdst=2, memtoreg=2.
  - SC: regdst=1, memtoreg=3.
- Cycle counts with ihit in the first cycle:
  - ALU ops: 4 cycles.
  - Branch/J/JR: 3 cycles.
  - SW: 4 + dhit wait.
  - Loads and successful SC: 5 + dhit wait.
- Link flag:
  - Set on LL dhit.
  - Cleared on link_inv, and on completion of any SC, successful or failed.
  - If link_inv coincides with LL dhit, set wins.
  - If link_inv coincides with SC in EXEC, SC fails.
- sc_result is 1 when an SC completes via MEM with dhit; it holds its value until the next SC.
- Decode tables match the existing single-cycle unit: regdst, extop, alu_src, alu_op. LL decodes like LW; SC decodes like SW for the address path.
- HALT: halt=1, all enables 0, pc_wen=0. Only nRST exits this state.

Test Plan:
- Reset, ADDU with ihit after 2 wait cycles -> state_o 0,0,0,1,2,4,0; regwr=1 and pc_wen=1 only in the WB cycle; iREN=1 for 3 cycles.
- LW, dhit after 3 wait cycles -> dREN=1 for 4 cycles steady; WB has memtoreg=1, regdst=1, regwr=1; total 8 cycles.
- BEQ with zero=1 -> EXEC: pc_wen=1, pc_src=1, regwr=0. BNE with zero=1 -> pc_src=0. Both return to FETCH after 3 cycles.
- LL then SC -> SC dWEN=1, sc_result=1, regwr with memtoreg=3. LL, link_inv pulse, then SC -> dWEN never asserted, sc_result=0, WB regwr=1.
- HALT opcode (0x3F) -> halt=1 and held indefinitely, iREN=0. nRST low during a MEM wait -> dREN drops immediately, state_o=0.
- Opcode 0x3E with HALT_ON_ILLEGAL=0 -> DECODE asserts pc_wen=1, pc_src=0, no regwr; returns to FETCH.
